switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
Input-side conditioner between the board switches and PORT_A of the I/O buffer.
- Synchronises the raw asynchronous switch bus to clk and debounces each bit with a shared sample tick and per-bit stability counters.
- Reports which bits changed so software sees only clean, stable values.
- Its output drives the PORT_A input of the I/O buffer directly.

Parameters:
WIDTH, 32, number of switch bits
SYNC_STAGES, 2, synchroniser flops per bit (>=2)
TICK_DIV, 50000, clk cycles per debounce sample tick (>=1)
STABLE_COUNT, 4, consecutive differing ticks needed to accept a new level (>=1)

Ports:
clk  input  1  system clock (single clock domain)
rst  input  1  synchronous, active-high reset
switch_in  input  WIDTH  raw asynchronous switch levels
sw_out  output  WIDTH  debounced switch levels, to I/O buffer PORT_A
sw_changed  output  WIDTH  one-cycle pulse mask of bits that flipped this cycle

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All state is sampled on the rising clk edge while rst=1.
- Reset values: synchroniser flops 0, tick counter 0, all per-bit counters 0, sw_out 0, sw_changed 0. Reset overrides every other action in that cycle.
- Synchroniser: each bit passes through SYNC_STAGES flops. sync[i] is the last stage. There is no other path from switch_in into the logic.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly one cycle when counter==TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- Per-bit debounce. Counter cnt[i] is clog2(STABLE_COUNT+1) bits wide. Actions occur only on edges where tick=1.
  - If sync[i]==sw_out[i]: cnt[i]<=0.
  - If sync[i]!=sw_out[i] and cnt[i]<STABLE_COUNT-1: cnt[i]<=cnt[i]+1.
  - If sync[i]!=sw_out[i] and cnt[i]==STABLE_COUNT-1: sw_out[i]<=~sw_out[i] and cnt[i]<=0.
  - On non-tick edges: cnt[i] and sw_out[i] hold.
- Net effect: a new level is accepted only after STABLE_COUNT consecutive ticks sample the differing value. Any intervening tick that samples the old value restarts the count.
- sw_changed:
  - Registered. Equals old sw_out XOR new sw_out on the edge where sw_out updates; 0 on every other edge.
  - Never high for two consecutive cycles on the same bit.
- Latency: sw_out changes SYNC_STAGES + (STABLE_COUNT-1)*TICK_DIV + 1 to SYNC_STAGES + STABLE_COUNT*TICK_DIV cycles after a clean input step.
- Bits are independent. Several bits may flip on the same edge; sw_changed then shows all of them in one pulse.
- Reset mid-debounce: partial counts are discarded and sw_out returns to 0 even if the switches are held high. The full debounce latency applies again after rst falls.
- No combinational path from any input to any output.

Optional Feature:
Macro SWCOND_IRQ_EN.
- When defined, three extra ports are added:
  - irq_ack  input  WIDTH  clear mask, bits to acknowledge
  - pending  output  WIDTH  sticky change flags
  - irq  output  1  interrupt request
- Per edge: pending <= (pending & ~irq_ack) | sw_changed_next, where sw_changed_next is the value sw_changed takes on that edge.
- Set wins over a simultaneous ack on the same bit.
- irq = |pending (combinational from the pending register).
- Reset values: pending 0, irq 0.
- When undefined: these ports and all associated logic are absent, and the base behaviour is unchanged.

Test Plan:
Use TICK_DIV=4, STABLE_COUNT=3, SYNC_STAGES=2, WIDTH=32.
1. rst=1 for 3 cycles with switch_in=0xFFFF_FFFF -> sw_out=0, sw_changed=0 throughout. Release rst, hold input -> sw_out=0xFFFF_FFFF 11..14 cycles later, with a single sw_changed=0xFFFF_FFFF pulse.
2. From sw_out=0, step switch_in to 0x0000_0001 -> sw_out[0] rises 11..14 cycles after the step. sw_changed=0x1 for exactly that one cycle; all other bits stay 0.
3. Toggle switch_in[5] every 3 cycles for 60 cycles, then hold 0 -> sw_out[5] stays 0 and sw_changed[5] never pulses.
4. Step switch_in 0x0 -> 0x0000_00FF -> sw_out=0x0000_00FF via one sw_changed=0x0000_00FF pulse. Then step to 0x0000_000F -> one pulse of 0x0000_00F0.
5. Hold switch_in[3]=1 for 2 ticks, then pulse rst for 1 cycle while still holding -> sw_out[3]=0 immediately after reset. It rises 11..14 cycles after rst falls, not earlier.
6. (SWCOND_IRQ_EN) Flip bit 0 -> pending=0x1 and irq=1 the same edge sw_changed pulses. Then drive irq_ack=0x1 on the edge where bit 2 flips -> pending=0x4 and irq=1. Then irq_ack=0x4 -> pending=0 and irq=0.

Source files
------------

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronises and debounces the board switch bus that
// feeds PORT_A of the I/O buffer. Each bit goes through a flop synchroniser.
// A new level is accepted only after STABLE_COUNT consecutive sample ticks
// all see that level. sw_changed pulses for one cycle on each accepted flip.
// Optional macro SWCOND_IRQ_EN adds sticky pending flags, an ack mask and an
// interrupt request.
module switch_conditioner #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed
`ifdef SWCOND_IRQ_EN
    ,
    input  logic [WIDTH-1:0] irq_ack,
    output logic [WIDTH-1:0] pending,
    output logic             irq
`endif
);

    localparam int unsigned CW = $clog2(STABLE_COUNT + 1);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] sw_d;
    logic [WIDTH-1:0] changed_d;

    assign sync = sync_q[SYNC_STAGES-1];
    assign tick = (tick_cnt == TICK_LAST);

    // Multi-flop synchroniser; the only path from switch_in into the logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= switch_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Free-running sample tick divider, wraps at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // Per-bit stability counting on tick edges; flip after STABLE_COUNT differing ticks.
    always_comb begin
        sw_d = sw_out;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync[i] == sw_out[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i]  = ~sw_out[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        changed_d = sw_d ^ sw_out;
    end

    // Debounce state, debounced level and change pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            sw_out     <= '0;
            sw_changed <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            sw_out     <= sw_d;
            sw_changed <= changed_d;
        end
    end

`ifdef SWCOND_IRQ_EN
    // Sticky change flags; a new change wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~irq_ack) | changed_d;
    end

    assign irq = |pending;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner (TICK_DIV=4, STABLE_COUNT=3).
// Expected sw_changed pulses are queued when the switch level is driven and
// matched by a monitor when the DUT pulses, within the 11..14 cycle window.
module tb_switch_conditioner;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] switch_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] sw_changed;
`ifdef SWCOND_IRQ_EN
    logic [WIDTH-1:0] irq_ack;
    logic [WIDTH-1:0] pending;
    logic             irq;
`endif

    switch_conditioner #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(2),
        .TICK_DIV(4),
        .STABLE_COUNT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch_in(switch_in),
        .sw_out(sw_out),
        .sw_changed(sw_changed)
`ifdef SWCOND_IRQ_EN
        ,
        .irq_ack(irq_ack),
        .pending(pending),
        .irq(irq)
`endif
    );

    typedef struct {
        logic [31:0] mask;
        logic [31:0] value;
        int unsigned lo;
        int unsigned hi;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned nrs = 0;
    logic        rst_last = 1'b1;
    logic [31:0] prev_sw = '0;
    logic [31:0] prev_chg = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Edge bookkeeping: total edges, and edges since the last reset edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_last <= rst;
        nrs      <= rst ? 0 : nrs + 1;
    end

    // Monitor: match pulses against the scoreboard and police sw_out changes.
    always @(negedge clk) begin
        if (!rst_last) begin
            if (sw_changed != '0) begin
                check("chg_vs_out", sw_changed, sw_out ^ prev_sw);
                check("no_back2back", sw_changed & prev_chg, '0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", sw_changed, '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_mask", sw_changed, e.mask);
                    check("pulse_sw_out", sw_out, e.value);
                    check("pulse_latency_ok", {31'b0, (cyc >= e.lo) && (cyc <= e.hi)}, 32'd1);
                end
            end else if (sw_out !== prev_sw) begin
                check("silent_change", sw_out, prev_sw);
            end
            if (exp_q.size() != 0 && cyc > exp_q[0].hi) begin
                check("late_pulse_cycle", cyc, exp_q[0].hi);
                void'(exp_q.pop_front());
            end
        end
        prev_sw  = sw_out;
        prev_chg = sw_changed;
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] mask, input logic [31:0] value);
        exp_t e;
        e = '{mask, value, cyc + 11, cyc + 14};
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [31:0] val, input logic [31:0] mask, input logic [31:0] value);
        switch_in = val;
        push_exp(mask, value);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) nstep();
        check("drain", exp_q.size(), 0);
        repeat (3) nstep();
    endtask

    initial begin
        rst       = 1'b1;
        switch_in = '1;
`ifdef SWCOND_IRQ_EN
        irq_ack   = '0;
`endif
        // 1: reset with switches high, then release
        repeat (3) begin
            nstep();
            check("rst_sw_out", sw_out, '0);
            check("rst_sw_changed", sw_changed, '0);
`ifdef SWCOND_IRQ_EN
            check("rst_pending", pending, '0);
            check("rst_irq", {31'b0, irq}, '0);
`endif
        end
        rst = 1'b0;
        push_exp('1, '1);
        drain();

        // 2: back to zero, then single bit 0 step
        apply(32'h0, 32'hFFFF_FFFF, 32'h0);
        drain();
        apply(32'h1, 32'h1, 32'h1);
        drain();

        // 3: bit 5 bouncing with period 6 must never be accepted
        for (int i = 0; i < 20; i++) begin
            switch_in[5] = ~switch_in[5];
            repeat (3) nstep();
        end
        switch_in = 32'h1;
        repeat (20) nstep();
        check("bounce_bit5", {31'b0, sw_out[5]}, '0);
        check("bounce_queue", exp_q.size(), 0);

        // 4: multi-bit flips in a single pulse
        apply(32'h0, 32'h1, 32'h0);
        drain();
        apply(32'hFF, 32'hFF, 32'hFF);
        drain();
        apply(32'h0F, 32'hF0, 32'h0F);
        drain();
        apply(32'h0, 32'h0F, 32'h0);
        drain();

        // 5: reset mid-debounce discards progress
        switch_in = 32'h8;
        repeat (8) nstep();
        check("mid_debounce_sw_out", sw_out, '0);
        rst = 1'b1;
        nstep();
        check("mid_rst_sw_out", sw_out, '0);
        check("mid_rst_sw_changed", sw_changed, '0);
        rst = 1'b0;
        push_exp(32'h8, 32'h8);
        drain();

`ifdef SWCOND_IRQ_EN
        // 6: pending / irq behaviour
        begin
            int unsigned c0, t1, flip;
            irq_ack = '1;
            nstep();
            irq_ack = '0;
            check("ack_all_pending", pending, '0);
            check("ack_all_irq", {31'b0, irq}, '0);

            apply(32'h9, 32'h1, 32'h9);
            for (int i = 0; i < 20; i++) begin
                nstep();
                if (sw_changed != '0) break;
            end
            check("b0_changed", sw_changed, 32'h1);
            check("b0_pending", pending, 32'h1);
            check("b0_irq", {31'b0, irq}, 32'd1);

            // Flip edge: third tick (every 4th edge since reset) seeing the synced level.
            apply(32'hD, 32'h4, 32'hD);
            c0   = nrs;
            t1   = ((c0 + 3 + 3) / 4) * 4;
            flip = t1 + 8;
            for (int i = 0; i < 20 && nrs + 1 < flip; i++) nstep();
            irq_ack = 32'h1;
            nstep();
            irq_ack = '0;
            check("b2_changed", sw_changed, 32'h4);
            check("b2_pending", pending, 32'h4);
            check("b2_irq", {31'b0, irq}, 32'd1);
            irq_ack = 32'h4;
            nstep();
            irq_ack = '0;
            check("ack4_pending", pending, '0);
            check("ack4_irq", {31'b0, irq}, '0);
            drain();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
